// File: rtl/elastic_pkg.sv
// Shared definitions for the elastic operator: op codes, op-name decoding and port-count limits.
package elastic_pkg;

  localparam int MAX_INPUT_SIZE  = 3;
  localparam int MAX_OUTPUT_SIZE = 8;

  typedef enum logic [3:0] {
    OP_REG,
    OP_IN,
    OP_OUT,
    OP_ADDI,
    OP_SUBI,
    OP_MULI,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_BAD
  } op_e;

  function automatic op_e op_from_name(input string name);
    op_e code;
    if      (name == "reg")  code = OP_REG;
    else if (name == "in")   code = OP_IN;
    else if (name == "out")  code = OP_OUT;
    else if (name == "addi") code = OP_ADDI;
    else if (name == "subi") code = OP_SUBI;
    else if (name == "muli") code = OP_MULI;
    else if (name == "add")  code = OP_ADD;
    else if (name == "sub")  code = OP_SUB;
    else if (name == "mul")  code = OP_MUL;
    else                     code = OP_BAD;
    return code;
  endfunction

  // Unary ops take exactly one operand port; the n-ary ones take two or three.
  function automatic logic op_is_unary(input op_e code);
    return (code == OP_ADD || code == OP_SUB || code == OP_MUL) ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/elastic_result_fifo.sv
// Result buffer: DEPTH-entry circular FIFO, write and read visible one edge later; push when full
// and pop when empty are dropped, head reads as zero while empty.
module elastic_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("elastic_result_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == CAP);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/elastic_operator.sv
// Elastic operator: per-operand req/ack capture, result pushed one edge after the last operand,
// fanned out to independent consumers; a full buffer holds operands and keeps req_l low.
module elastic_operator
  import elastic_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter string                 OP          = "reg",
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
  parameter int                    INPUT_SIZE  = 1,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH):0]           level,
  output logic [31:0]                      produced,
  output logic                             proto_err
);

  localparam op_e OPC = op_from_name(OP);

  if (OPC == OP_BAD) begin : g_bad_op
    $error("elastic_operator: unknown OP");
  end
  if (INPUT_SIZE < 1 || INPUT_SIZE > MAX_INPUT_SIZE ||
      (op_is_unary(OPC) != (INPUT_SIZE == 1))) begin : g_bad_inputs
    $error("elastic_operator: INPUT_SIZE illegal for OP");
  end
  if (OUTPUT_SIZE < 1 || OUTPUT_SIZE > MAX_OUTPUT_SIZE) begin : g_bad_outputs
    $error("elastic_operator: OUTPUT_SIZE out of range");
  end

  logic [DATA_WIDTH-1:0]  opnd [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  has;
  logic [INPUT_SIZE-1:0]  take;
  logic [OUTPUT_SIZE-1:0] served;
  logic [DATA_WIDTH-1:0]  result;
  logic                   started;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign take = ack_l & ~has;
  assign push = (&has) && !full;
  // Every consumer has been served exactly when the final ack pulse is high.
  assign pop  = &served;

  always_comb begin
    result = opnd[0];
    case (OPC)
      OP_ADDI: result = opnd[0] + IMMEDIATE;
      OP_SUBI: result = opnd[0] - IMMEDIATE;
      OP_MULI: result = opnd[0] * IMMEDIATE;
      OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result = result + opnd[i];
      OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result = result - opnd[i];
      OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result = result * opnd[i];
      default: result = opnd[0];
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (rst)          opnd[i] <= '0;
      else if (take[i]) opnd[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // started delays the first req_l by one edge after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      started   <= 1'b0;
      has       <= '0;
      req_l     <= '0;
      produced  <= '0;
      proto_err <= 1'b0;
    end else begin
      started   <= 1'b1;
      proto_err <= proto_err | (|(ack_l & has));
      if (push) begin
        has      <= '0;
        produced <= produced + 32'd1;
      end else begin
        has <= has | take;
      end
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (take[i])                             req_l[i] <= 1'b0;
        else if (started && !has[i] && !req_l[i]) req_l[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pop) begin
      ack_r  <= '0;
      served <= '0;
    end else begin
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        ack_r[j] <= req_r[j] && !served[j] && !ack_r[j] && !empty;
        if (req_r[j] && !served[j] && !ack_r[j] && !empty) served[j] <= 1'b1;
      end
    end
  end

  elastic_result_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (result),
    .pop   (pop),
    .rdata (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_elastic_operator.sv
// Scoreboard bench for elastic_operator: four configurations (addi, 2-input add, 3-way fan-out, depth 4).
module tb_elastic_operator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic        a_req_l, a_ack_l, a_req_r, a_ack_r, a_perr;
  logic [31:0] a_din, a_dout, a_prod;
  logic [1:0]  a_level;

  logic [1:0]  s_req_l, s_ack_l, s_level;
  logic [63:0] s_din;
  logic        s_req_r, s_ack_r, s_perr;
  logic [31:0] s_dout, s_prod;

  logic        f_req_l, f_ack_l, f_perr;
  logic [2:0]  f_req_r, f_ack_r;
  logic [31:0] f_din, f_dout, f_prod;
  logic [1:0]  f_level;

  logic        d_req_l, d_ack_l, d_req_r, d_ack_r, d_perr;
  logic [31:0] d_din, d_dout, d_prod;
  logic [2:0]  d_level;

  logic [31:0] q_a [$];
  logic [31:0] q_s [$];
  logic [31:0] q_f [3][$];
  logic [31:0] q_d [$];
  logic [31:0] exp_v;
  int          cnt [3];
  int          got;
  logic [31:0] a_tab [3];
  logic [31:0] b_tab [3];
  logic [31:0] r_tab [3];

  elastic_operator #(.DATA_WIDTH(32), .OP("addi"), .IMMEDIATE(32'd2), .INPUT_SIZE(1),
                     .OUTPUT_SIZE(1), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din), .req_r(a_req_r),
    .ack_r(a_ack_r), .dout(a_dout), .level(a_level), .produced(a_prod), .proto_err(a_perr));

  elastic_operator #(.DATA_WIDTH(32), .OP("add"), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(2)) u_s (
    .clk(clk), .rst(rst), .req_l(s_req_l), .ack_l(s_ack_l), .din(s_din), .req_r(s_req_r),
    .ack_r(s_ack_r), .dout(s_dout), .level(s_level), .produced(s_prod), .proto_err(s_perr));

  elastic_operator #(.DATA_WIDTH(32), .OP("reg"), .INPUT_SIZE(1), .OUTPUT_SIZE(3), .DEPTH(2)) u_f (
    .clk(clk), .rst(rst), .req_l(f_req_l), .ack_l(f_ack_l), .din(f_din), .req_r(f_req_r),
    .ack_r(f_ack_r), .dout(f_dout), .level(f_level), .produced(f_prod), .proto_err(f_perr));

  elastic_operator #(.DATA_WIDTH(32), .OP("reg"), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(4)) u_d (
    .clk(clk), .rst(rst), .req_l(d_req_l), .ack_l(d_ack_l), .din(d_din), .req_r(d_req_r),
    .ack_r(d_ack_r), .dout(d_dout), .level(d_level), .produced(d_prod), .proto_err(d_perr));

  // One-operand producer: wait for req_l, then hold ack_l for one cycle with the value.
  task automatic drive1(input int which, input logic [31:0] v);
    int   t;
    logic r;
    t = 0;
    do begin
      @(negedge clk);
      r = (which == 0) ? a_req_l : (which == 1) ? f_req_l : d_req_l;
      t++;
    end while (!r && t < 300);
    n_vec++;
    if (!r) begin
      n_err++;
      $display("FAIL req_l_wait dut%0d: req_l=%b, required 1", which, r);
    end else begin
      case (which)
        0:       begin a_ack_l = 1'b1; a_din = v; end
        1:       begin f_ack_l = 1'b1; f_din = v; end
        default: begin d_ack_l = 1'b1; d_din = v; end
      endcase
      @(negedge clk);
      a_ack_l = 1'b0; f_ack_l = 1'b0; d_ack_l = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_ack_l = 1'b1; a_din = 32'h1234; a_req_r = 1'b1;
    repeat (3) @(negedge clk);
    n_vec += 7;
    if (a_req_l !== 1'b0)  begin n_err++; $display("FAIL rst_req_l: got %b want 0", a_req_l); end
    if (a_ack_r !== 1'b0)  begin n_err++; $display("FAIL rst_ack_r: got %b want 0", a_ack_r); end
    if (a_level !== 2'd0)  begin n_err++; $display("FAIL rst_level: got %0d want 0", a_level); end
    if (a_prod !== 32'd0)  begin n_err++; $display("FAIL rst_produced: got %0d want 0", a_prod); end
    if (a_perr !== 1'b0)   begin n_err++; $display("FAIL rst_proto_err: got %b want 0", a_perr); end
    if (a_dout !== 32'd0)  begin n_err++; $display("FAIL rst_dout: got %h want 0", a_dout); end
    if (f_ack_r !== 3'b000) begin n_err++; $display("FAIL rst_fan_ack_r: got %b want 000", f_ack_r); end
    rst = 1'b0; a_ack_l = 1'b0; a_req_r = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (a_req_l !== 1'b0) begin n_err++; $display("FAIL req_l_first_edge: got %b want 0", a_req_l); end
    if (a_level !== 2'd0) begin n_err++; $display("FAIL rst_ack_ignored_level: got %0d want 0", a_level); end
    if (a_perr !== 1'b0)  begin n_err++; $display("FAIL rst_ack_ignored_perr: got %b want 0", a_perr); end
    @(negedge clk);
    n_vec += 2;
    if (a_req_l !== 1'b1) begin n_err++; $display("FAIL req_l_second_edge: got %b want 1", a_req_l); end
    if (s_req_l !== 2'b11) begin n_err++; $display("FAIL req_l_second_edge_add: got %b want 11", s_req_l); end
  endtask

  task automatic test_addi_stream();
    a_req_r = 1'b1;
    got = 0;
    fork
      for (int v = 0; v < 10; v++) begin
        q_a.push_back(32'(v + 2));
        drive1(0, 32'(v));
      end
      begin
        int t;
        t = 0;
        while (got < 10 && t < 1000) begin
          @(negedge clk); t++;
          if (a_ack_r) begin
            got++; n_vec++;
            exp_v = (q_a.size() > 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
            if (a_dout !== exp_v) begin n_err++; $display("FAIL addi_dout: got %0d want %0d", a_dout, exp_v); end
          end
        end
        n_vec++;
        if (got != 10) begin n_err++; $display("FAIL addi_count: got %0d results want 10", got); end
      end
    join
    repeat (3) @(negedge clk);
    n_vec += 3;
    if (a_prod !== 32'd10) begin n_err++; $display("FAIL addi_produced: got %0d want 10", a_prod); end
    if (a_perr !== 1'b0)   begin n_err++; $display("FAIL addi_proto_err: got %b want 0", a_perr); end
    if (a_level !== 2'd0)  begin n_err++; $display("FAIL addi_level: got %0d want 0", a_level); end
  endtask

  task automatic test_add_wrap();
    a_tab = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
    b_tab = '{32'd7, 32'd1,         32'h8000_0001};
    r_tab = '{32'd12, 32'd0,        32'd1};
    s_req_r = 1'b1;
    got = 0;
    fork
      for (int k = 0; k < 3; k++) begin
        int t;
        q_s.push_back(r_tab[k]);
        t = 0;
        do begin @(negedge clk); t++; end while (s_req_l !== 2'b11 && t < 300);
        n_vec++;
        if (s_req_l !== 2'b11) begin n_err++; $display("FAIL add_req_l_wait: got %b want 11", s_req_l); end
        s_ack_l = 2'b11; s_din = {b_tab[k], a_tab[k]};
        @(negedge clk);
        s_ack_l = 2'b00;
      end
      begin
        int t;
        t = 0;
        while (got < 3 && t < 1000) begin
          @(negedge clk); t++;
          if (s_ack_r) begin
            got++; n_vec++;
            exp_v = (q_s.size() > 0) ? q_s.pop_front() : 32'hDEAD_BEEF;
            if (s_dout !== exp_v) begin n_err++; $display("FAIL add_dout: got %h want %h", s_dout, exp_v); end
          end
        end
        n_vec++;
        if (got != 3) begin n_err++; $display("FAIL add_count: got %0d results want 3", got); end
      end
    join
    n_vec++;
    if (s_prod !== 32'd3) begin n_err++; $display("FAIL add_produced: got %0d want 3", s_prod); end
  endtask

  task automatic test_fanout();
    cnt = '{0, 0, 0};
    f_req_r = 3'b011;
    fork
      for (int v = 0; v < 3; v++) begin
        for (int j = 0; j < 3; j++) q_f[j].push_back(32'hA0 + 32'(v));
        drive1(1, 32'hA0 + 32'(v));
      end
      begin
        for (int cyc = 0; cyc < 600; cyc++) begin
          if (cyc == 20) begin
            n_vec += 4;
            if (cnt[0] != 1) begin n_err++; $display("FAIL fan_stall_c0: got %0d acks want 1", cnt[0]); end
            if (cnt[1] != 1) begin n_err++; $display("FAIL fan_stall_c1: got %0d acks want 1", cnt[1]); end
            if (cnt[2] != 0) begin n_err++; $display("FAIL fan_stall_c2: got %0d acks want 0", cnt[2]); end
            if (f_level !== 2'd2) begin n_err++; $display("FAIL fan_no_pop_level: got %0d want 2", f_level); end
            f_req_r = 3'b111;
          end
          if (cyc > 20 && cnt[0] >= 3 && cnt[1] >= 3 && cnt[2] >= 3) break;
          @(negedge clk);
          for (int j = 0; j < 3; j++) begin
            if (f_ack_r[j]) begin
              cnt[j]++; n_vec++;
              exp_v = (q_f[j].size() > 0) ? q_f[j].pop_front() : 32'hDEAD_BEEF;
              if (f_dout !== exp_v) begin n_err++; $display("FAIL fan_dout_c%0d: got %h want %h", j, f_dout, exp_v); end
            end
          end
        end
        n_vec++;
        if (cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
          n_err++; $display("FAIL fan_counts: got %0d/%0d/%0d want 3/3/3", cnt[0], cnt[1], cnt[2]);
        end
      end
    join
  endtask

  task automatic test_depth_stall();
    d_req_r = 1'b0;
    got = 0;
    fork
      for (int v = 0; v < 6; v++) begin
        q_d.push_back(32'h10 + 32'(v));
        drive1(2, 32'h10 + 32'(v));
      end
      begin
        int t;
        repeat (40) @(negedge clk);
        n_vec += 3;
        if (d_level !== 3'd4) begin n_err++; $display("FAIL deep_level_sat: got %0d want 4", d_level); end
        if (d_req_l !== 1'b0) begin n_err++; $display("FAIL deep_req_l_low: got %b want 0", d_req_l); end
        if (u_d.has !== 1'b1) begin n_err++; $display("FAIL deep_has_held: got %b want 1", u_d.has); end
        d_req_r = 1'b1;
        t = 0;
        while (got < 6 && t < 1000) begin
          @(negedge clk); t++;
          if (d_ack_r) begin
            got++; n_vec++;
            exp_v = (q_d.size() > 0) ? q_d.pop_front() : 32'hDEAD_BEEF;
            if (d_dout !== exp_v) begin n_err++; $display("FAIL deep_dout: got %h want %h", d_dout, exp_v); end
          end
        end
        n_vec++;
        if (got != 6) begin n_err++; $display("FAIL deep_count: got %0d results want 6", got); end
      end
    join
    repeat (3) @(negedge clk);
    n_vec += 2;
    if (d_level !== 3'd0) begin n_err++; $display("FAIL deep_drained: got %0d want 0", d_level); end
    if (d_prod !== 32'd6) begin n_err++; $display("FAIL deep_produced: got %0d want 6", d_prod); end
  endtask

  task automatic test_proto_err();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!d_req_l && t < 300);
    d_ack_l = 1'b1; d_din = 32'h55;
    q_d.push_back(32'h55);
    @(negedge clk);
    d_din = 32'hBAD;
    @(negedge clk);
    d_ack_l = 1'b0;
    n_vec++;
    if (d_perr !== 1'b1) begin n_err++; $display("FAIL perr_set: got %b want 1", d_perr); end
    got = 0;
    repeat (15) begin
      @(negedge clk);
      if (d_ack_r) begin
        got++; n_vec++;
        exp_v = (q_d.size() > 0) ? q_d.pop_front() : 32'hDEAD_BEEF;
        if (d_dout !== exp_v) begin n_err++; $display("FAIL perr_dout: got %h want %h", d_dout, exp_v); end
      end
    end
    n_vec++;
    if (got != 1) begin n_err++; $display("FAIL perr_result_count: got %0d want 1", got); end
    q_d.push_back(32'h66);
    drive1(2, 32'h66);
    got = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_ack_r) begin
        got++; n_vec++;
        exp_v = (q_d.size() > 0) ? q_d.pop_front() : 32'hDEAD_BEEF;
        if (d_dout !== exp_v) begin n_err++; $display("FAIL perr_next_dout: got %h want %h", d_dout, exp_v); end
      end
    end
    n_vec += 2;
    if (got != 1) begin n_err++; $display("FAIL perr_next_count: got %0d want 1", got); end
    if (d_perr !== 1'b1) begin n_err++; $display("FAIL perr_sticky: got %b want 1", d_perr); end
  endtask

  task automatic test_mid_reset();
    int t;
    d_req_r = 1'b0;
    for (int v = 0; v < 3; v++) drive1(2, 32'h30 + 32'(v));
    t = 0;
    while (d_level !== 3'd3 && t < 20) begin @(negedge clk); t++; end
    n_vec++;
    if (d_level !== 3'd3) begin n_err++; $display("FAIL mrst_level_before: got %0d want 3", d_level); end
    rst = 1'b1; d_req_r = 1'b1;
    @(negedge clk);
    n_vec += 6;
    if (d_level !== 3'd0)  begin n_err++; $display("FAIL mrst_level: got %0d want 0", d_level); end
    if (d_ack_r !== 1'b0)  begin n_err++; $display("FAIL mrst_ack_r: got %b want 0", d_ack_r); end
    if (d_prod !== 32'd0)  begin n_err++; $display("FAIL mrst_produced: got %0d want 0", d_prod); end
    if (d_perr !== 1'b0)   begin n_err++; $display("FAIL mrst_proto_err: got %b want 0", d_perr); end
    if (d_dout !== 32'd0)  begin n_err++; $display("FAIL mrst_dout: got %h want 0", d_dout); end
    if (d_req_l !== 1'b0)  begin n_err++; $display("FAIL mrst_req_l: got %b want 0", d_req_l); end
    rst = 1'b0;
    q_d.delete();
    got = 0;
    fork
      for (int v = 0; v < 2; v++) begin
        q_d.push_back(32'h77 + 32'(v));
        drive1(2, 32'h77 + 32'(v));
      end
      begin
        repeat (60) begin
          @(negedge clk);
          if (d_ack_r) begin
            got++; n_vec++;
            exp_v = (q_d.size() > 0) ? q_d.pop_front() : 32'hDEAD_BEEF;
            if (d_dout !== exp_v) begin n_err++; $display("FAIL mrst_restart_dout: got %h want %h", d_dout, exp_v); end
          end
        end
      end
    join
    n_vec += 2;
    if (got != 2) begin n_err++; $display("FAIL mrst_restart_count: got %0d want 2", got); end
    if (d_prod !== 32'd2) begin n_err++; $display("FAIL mrst_restart_produced: got %0d want 2", d_prod); end
  endtask

  initial begin
    rst = 1'b1;
    a_ack_l = 1'b0; a_din = '0; a_req_r = 1'b0;
    s_ack_l = '0;   s_din = '0; s_req_r = 1'b0;
    f_ack_l = 1'b0; f_din = '0; f_req_r = '0;
    d_ack_l = 1'b0; d_din = '0; d_req_r = 1'b0;
    test_reset();
    test_addi_stream();
    test_add_wrap();
    test_fanout();
    test_depth_stall();
    test_proto_err();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_operator.md
ELASTIC_OPERATOR -- requirements
Module: elastic_operator

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter OP, default "reg": one of reg, in, out, addi, subi, muli (INPUT_SIZE=1) or add, sub, mul (INPUT_SIZE 2..3).
REQ-003 Parameter IMMEDIATE, default 0: constant operand for addi/subi/muli.
REQ-004 Parameter INPUT_SIZE, default 1: operand ports, legal range 1..3.
REQ-005 Parameter OUTPUT_SIZE, default 1: fan-out consumers, legal range 1..8.
REQ-006 Parameter DEPTH, default 2: result buffer entries, power of two, at least 2.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 req_l  output  INPUT_SIZE  per-operand request to upstream.
REQ-010 ack_l  input  INPUT_SIZE  per-operand acknowledge; din slice is valid while high.
REQ-011 din  input  DATA_WIDTH*INPUT_SIZE  operands; operand 0 occupies the LSBs.
REQ-012 req_r  input  OUTPUT_SIZE  per-consumer request.
REQ-013 ack_r  output  OUTPUT_SIZE  per-consumer acknowledge; each bit is a one-cycle pulse.
REQ-014 dout  output  DATA_WIDTH  result at the buffer head; valid while any ack_r bit is high.
REQ-015 level  output  $clog2(DEPTH)+1  number of occupied result entries.
REQ-016 produced  output  32  count of results pushed; wraps modulo 2^32.
REQ-017 proto_err  output  1  sticky protocol-error flag.

Function
REQ-018 Per operand i, the block SHALL raise req_l[i] one cycle after has[i]=0 and req_l[i]=0.
REQ-019 On a clock edge with ack_l[i]=1 and has[i]=0, the block SHALL capture the din slice i synchronously, set has[i], and drop req_l[i].
REQ-020 ack_l[i]=1 while has[i]=1 SHALL be ignored (data discarded) and SHALL set proto_err.
REQ-021 When all has bits are 1 and the buffer is not full, the block SHALL push the result at that edge, clear all has bits, and increment produced.
REQ-022 Push latency: result enters the buffer one edge after the last operand capture.
REQ-023 The full check SHALL use pre-pop occupancy; no push occurs when level=DEPTH, even if a pop occurs in the same cycle.
REQ-024 Arithmetic SHALL be modulo 2^DATA_WIDTH. sub = op0-op1[-op2]; subi = op0-IMMEDIATE; mul/muli keep the low DATA_WIDTH bits.
REQ-025 For each output j with req_r[j]=1, served[j]=0, ack_r[j]=0 and the buffer non-empty, the block SHALL assert ack_r[j] for the next cycle and set served[j].
REQ-026 dout SHALL equal the head entry and remain stable until the head is popped.
REQ-027 On the edge that ends the last outstanding ack_r pulse (all served bits set), the block SHALL pop the head and clear all served bits.
REQ-028 Consumers SHALL be served independently; a slow consumer stalls the pop but not another consumer's first ack for the same entry.
REQ-029 A simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 The buffer SHALL never overflow or underflow; ack_r is never issued when empty.

Reset
REQ-032 While rst=1: req_l=0, ack_r=0, has=0, served=0, level=0, produced=0, proto_err=0, pointers=0, dout=0.
REQ-033 ack_l or req_r asserted during the rst cycle SHALL be ignored.
REQ-034 Reset mid-operation SHALL discard buffered results and captured operands with no ack_r emitted.
REQ-035 req_l SHALL first rise on the second edge after rst deasserts.

Structure
REQ-036 Shared package elastic_pkg SHALL hold the op-code enum, the op-name-to-code mapping function, and the OUTPUT_SIZE/INPUT_SIZE limit constants.
REQ-037 The result buffer SHALL be a sub-module elastic_result_fifo (parametrised by DATA_WIDTH and DEPTH, push/pop/full/empty/level).
REQ-038 Operator arithmetic SHALL be combinational logic inside elastic_operator.

Verification
REQ-039 addi, IMMEDIATE=2, producer sends 0..9, one consumer always requesting -> dout sequence 2..11, produced=10, proto_err=0.
REQ-040 add, INPUT_SIZE=2, operands (5,7) and (0xFFFFFFFF,1) -> results 12 and 0 (wrap).
REQ-041 OUTPUT_SIZE=3, consumer 2 holds req_r low for 20 cycles -> consumers 0 and 1 each ack entry 0 once; no pop until consumer 2 acks; then all three receive identical values.
REQ-042 DEPTH=4, consumer stalled, 6 operands offered -> level saturates at 4, req_l stays low with has=1, no data lost after release, output order preserved.
REQ-043 Extra ack_l pulse while has=1 -> proto_err=1 sticky, discarded value never appears on dout.
REQ-044 rst pulsed with level=3 -> level=0, ack_r=0 next cycle, produced=0, stream restarts cleanly.
